// File: rtl/ycbcr_pkg.sv
// Shared constants, types and coefficient helper for the YCbCr-to-RGB pipeline.
// Full-range BT.601 coefficients are scaled by 2^FRAC.
package ycbcr_pkg;

  localparam int PIX_W      = 8;
  localparam int CHROMA_OFS = 128;
  localparam int ROUND      = 128;
  localparam int FRAC       = 8;

  localparam int K_RCR = 359;
  localparam int K_GCB = 88;
  localparam int K_GCR = 183;
  localparam int K_BCB = 454;

  localparam int DIFF_W = 9;
  localparam int PROD_W = 18;
  localparam int ACC_W  = 20;

  typedef logic signed [DIFF_W-1:0] diff_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Channel index into the per-colour arrays of the output stage.
  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  // Signed chroma difference times a positive coefficient; fits in PROD_W bits.
  function automatic prod_t mul_coef(input diff_t d, input int k);
    prod_t d_ext;
    prod_t k_ext;
    d_ext = prod_t'(d);
    k_ext = prod_t'(k);
    return d_ext * k_ext;
  endfunction

  // Remove the 128 offset from an unsigned chroma sample.
  function automatic diff_t chroma_diff(input logic [PIX_W-1:0] c);
    diff_t c_ext;
    c_ext = diff_t'({1'b0, c});
    return c_ext - diff_t'(CHROMA_OFS);
  endfunction

endpackage

// File: rtl/clamp_u8.sv
// Saturates a signed, already-shifted accumulator value to the unsigned 0..255 range.
module clamp_u8
  import ycbcr_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_i,
  output logic [PIX_W-1:0]        pix_o
);

  always_comb begin
    pix_o = acc_i[PIX_W-1:0];
    if (acc_i[ACC_W-1]) begin
      pix_o = '0;
    end else if (|acc_i[ACC_W-2:PIX_W]) begin
      pix_o = '1;
    end
  end

endmodule

// File: rtl/ycbcr_to_rgb.sv
// Three-stage flow-controlled YCbCr-to-RGB converter: offsets, products, then
// rounded sums with saturation. All stages advance together when the output can move.
module ycbcr_to_rgb
  import ycbcr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] luma_ch,
  input  logic [WIDTH-1:0] cb_ch,
  input  logic [WIDTH-1:0] cr_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] red_ch,
  output logic [WIDTH-1:0] green_ch,
  output logic [WIDTH-1:0] blue_ch
);

  if (WIDTH != PIX_W) begin : g_width_check
    $error("ycbcr_to_rgb: only WIDTH == 8 is supported");
  end

  logic adv;

  // Stage 1: luma and offset-removed chroma.
  logic             v1_q;
  logic [PIX_W-1:0] y1_q;
  diff_t            db1_q, dr1_q;
  diff_t            db1_d, dr1_d;

  // Stage 2: coefficient products.
  logic             v2_q;
  logic [PIX_W-1:0] y2_q;
  prod_t            p_rcr_q, p_gcb_q, p_gcr_q, p_bcb_q;
  prod_t            p_rcr_d, p_gcb_d, p_gcr_d, p_bcb_d;

  // Stage 3: saturated RGB.
  logic             v3_q;
  acc_t             acc_d [3];
  logic [PIX_W-1:0] rgb_d [3];
  logic [PIX_W-1:0] rgb_q [3];

  assign adv      = ~v3_q | out_ready;
  assign in_ready = adv;

  assign db1_d = chroma_diff(cb_ch);
  assign dr1_d = chroma_diff(cr_ch);

  assign p_rcr_d = mul_coef(dr1_q, K_RCR);
  assign p_gcb_d = mul_coef(db1_q, K_GCB);
  assign p_gcr_d = mul_coef(dr1_q, K_GCR);
  assign p_bcb_d = mul_coef(db1_q, K_BCB);

  always_comb begin
    acc_t y_term;
    acc_t rnd;
    y_term = acc_t'({{(ACC_W-PIX_W-FRAC){1'b0}}, y2_q, {FRAC{1'b0}}});
    rnd    = acc_t'(ROUND);
    acc_d[CH_R] = y_term + acc_t'(p_rcr_q) + rnd;
    acc_d[CH_G] = y_term - acc_t'(p_gcb_q) - acc_t'(p_gcr_q) + rnd;
    acc_d[CH_B] = y_term + acc_t'(p_bcb_q) + rnd;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_clamp
    acc_t shifted;
    assign shifted = acc_d[gi] >>> FRAC;
    clamp_u8 u_clamp (
      .acc_i (shifted),
      .pix_o (rgb_d[gi])
    );
  end

  // Data registers need no reset; only valids and the visible outputs are cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      rgb_q[CH_R]  <= '0;
      rgb_q[CH_G]  <= '0;
      rgb_q[CH_B]  <= '0;
    end else if (adv) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      rgb_q[CH_R] <= rgb_d[CH_R];
      rgb_q[CH_G] <= rgb_d[CH_G];
      rgb_q[CH_B] <= rgb_d[CH_B];
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      y1_q    <= luma_ch;
      db1_q   <= db1_d;
      dr1_q   <= dr1_d;
      y2_q    <= y1_q;
      p_rcr_q <= p_rcr_d;
      p_gcb_q <= p_gcb_d;
      p_gcr_q <= p_gcr_d;
      p_bcb_q <= p_bcb_d;
    end
  end

  assign out_valid = v3_q;
  assign red_ch    = rgb_q[CH_R];
  assign green_ch  = rgb_q[CH_G];
  assign blue_ch   = rgb_q[CH_B];

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// Directed bench for ycbcr_to_rgb: reset, colour vectors, saturation, stalls,
// bubbles and mid-stream reset, with an integer reference model for streams.
module tb_ycbcr_to_rgb;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] luma_ch, cb_ch, cr_ch;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] red_ch, green_ch, blue_ch;

  int n_checks = 0;
  int n_fails  = 0;

  ycbcr_to_rgb #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .luma_ch   (luma_ch),
    .cb_ch     (cb_ch),
    .cr_ch     (cr_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .red_ch    (red_ch),
    .green_ch  (green_ch),
    .blue_ch   (blue_ch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int clip(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Reference conversion straight from the defining equations.
  function automatic logic [23:0] ref_px(input int y, input int cb, input int cr);
    int db, dr, r, g, b;
    db = cb - 128;
    dr = cr - 128;
    r = (256*y + 359*dr + 128) >>> 8;
    g = (256*y - 88*db - 183*dr + 128) >>> 8;
    b = (256*y + 454*db + 128) >>> 8;
    return {8'(clip(r)), 8'(clip(g)), 8'(clip(b))};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) step();
  endtask

  // Sends one pixel into an empty pipeline and reports what came out and when.
  task automatic run_single(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                            output logic [7:0] r, output logic [7:0] g, output logic [7:0] b,
                            output int lat, output logic acc);
    luma_ch   = y;
    cb_ch     = cb;
    cr_ch     = cr;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 acc = in_ready;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    r = red_ch;
    g = green_ch;
    b = blue_ch;
    step();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    luma_ch   = 8'd200;
    cb_ch     = 8'd10;
    cr_ch     = 8'd240;
    step();
    step();
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if ({red_ch, green_ch, blue_ch} !== 24'h0) begin
      n_fails++; $display("FAIL reset_rgb: got %h want 000000", {red_ch, green_ch, blue_ch});
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    $display("reset: out_valid=%b rgb=%h in_ready=%b", out_valid, {red_ch, green_ch, blue_ch}, in_ready);
  endtask

  task automatic test_grey();
    logic [7:0] r, g, b;
    int lat;
    logic acc;
    run_single(8'd128, 8'd128, 8'd128, r, g, b, lat, acc);
    $display("grey: in 128/128/128 -> %0d/%0d/%0d latency %0d", r, g, b, lat);
    n_checks++;
    if (acc !== 1'b1) begin n_fails++; $display("FAIL grey_accept: got %b want 1", acc); end
    n_checks++;
    if (lat != 3) begin n_fails++; $display("FAIL grey_latency: got %0d want 3", lat); end
    n_checks++;
    if ({r, g, b} !== {8'd128, 8'd128, 8'd128}) begin
      n_fails++; $display("FAIL grey_rgb: got %0d/%0d/%0d want 128/128/128", r, g, b);
    end
  endtask

  task automatic test_red();
    logic [7:0] r, g, b;
    int lat;
    logic acc;
    run_single(8'd76, 8'd85, 8'd255, r, g, b, lat, acc);
    $display("red: in 76/85/255 -> %0d/%0d/%0d latency %0d", r, g, b, lat);
    n_checks++;
    if (lat != 3) begin n_fails++; $display("FAIL red_latency: got %0d want 3", lat); end
    n_checks++;
    if ({r, g, b} !== {8'd254, 8'd0, 8'd0}) begin
      n_fails++; $display("FAIL red_rgb: got %0d/%0d/%0d want 254/0/0", r, g, b);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] r, g, b;
    int lat;
    logic acc;
    run_single(8'd255, 8'd128, 8'd255, r, g, b, lat, acc);
    $display("sat_high: in 255/128/255 -> %0d/%0d/%0d", r, g, b);
    n_checks++;
    if ({r, g, b} !== {8'd255, 8'd164, 8'd255}) begin
      n_fails++; $display("FAIL sat_high_rgb: got %0d/%0d/%0d want 255/164/255", r, g, b);
    end
    run_single(8'd0, 8'd128, 8'd0, r, g, b, lat, acc);
    $display("sat_low: in 0/128/0 -> %0d/%0d/%0d", r, g, b);
    n_checks++;
    if ({r, g, b} !== {8'd0, 8'd92, 8'd0}) begin
      n_fails++; $display("FAIL sat_low_rgb: got %0d/%0d/%0d want 0/92/0", r, g, b);
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] q[$];
    logic [23:0] held, expv;
    logic [7:0]  lfsr;
    logic        stall_prev;
    int          sent, got;
    lfsr       = 8'hA5;
    stall_prev = 1'b0;
    sent       = 0;
    got        = 0;
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      lfsr      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      out_ready = lfsr[0];
      in_valid  = (sent < 10);
      luma_ch   = 8'((sent * 25 + 3) & 255);
      cb_ch     = 8'((sent * 37 + 11) & 255);
      cr_ch     = 8'((sent * 53 + 200) & 255);
      #1;
      if (stall_prev) begin
        n_checks++;
        if (out_valid !== 1'b1 || {red_ch, green_ch, blue_ch} !== held) begin
          n_fails++;
          $display("FAIL bp_stable: got v=%b %h want v=1 %h", out_valid, {red_ch, green_ch, blue_ch}, held);
        end
      end
      stall_prev = 1'b0;
      if (out_valid && !out_ready) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fails++; $display("FAIL bp_in_ready: got %b want 0", in_ready);
        end
        held       = {red_ch, green_ch, blue_ch};
        stall_prev = 1'b1;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fails++; $display("FAIL bp_extra_output: got %h want none", {red_ch, green_ch, blue_ch});
        end else begin
          expv = q.pop_front();
          if ({red_ch, green_ch, blue_ch} !== expv) begin
            n_fails++; $display("FAIL bp_data[%0d]: got %h want %h", got, {red_ch, green_ch, blue_ch}, expv);
          end
          $display("backpressure: out #%0d rgb=%h want %h", got, {red_ch, green_ch, blue_ch}, expv);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_px(int'(luma_ch), int'(cb_ch), int'(cr_ch)));
        sent++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (got != 10) begin n_fails++; $display("FAIL bp_count: got %0d want 10", got); end
    idle_cycles(4);
  endtask

  task automatic test_bubbles();
    logic [4:0]  pat;
    logic        exp_v;
    logic [23:0] expv;
    int          got;
    pat = 5'b01101;  // bit k drives cycle k: 1,0,1,1,0
    got = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_valid  = (cyc < 5) ? pat[cyc] : 1'b0;
      luma_ch   = 8'(40 + cyc * 30);
      cb_ch     = 8'(100 + cyc * 10);
      cr_ch     = 8'(160 - cyc * 12);
      out_ready = 1'b1;
      #1;
      exp_v = (cyc >= 3 && cyc < 8) ? pat[cyc-3] : 1'b0;
      n_checks++;
      if (out_valid !== exp_v) begin
        n_fails++; $display("FAIL bubble_valid[%0d]: got %b want %b", cyc, out_valid, exp_v);
      end
      if (out_valid && exp_v) begin
        expv = ref_px(40 + (cyc-3) * 30, 100 + (cyc-3) * 10, 160 - (cyc-3) * 12);
        n_checks++;
        if ({red_ch, green_ch, blue_ch} !== expv) begin
          n_fails++; $display("FAIL bubble_data[%0d]: got %h want %h", cyc, {red_ch, green_ch, blue_ch}, expv);
        end
        got++;
      end
      $display("bubbles: cycle %0d out_valid=%b rgb=%h", cyc, out_valid, {red_ch, green_ch, blue_ch});
      step();
    end
    n_checks++;
    if (got != 3) begin n_fails++; $display("FAIL bubble_count: got %0d want 3", got); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      luma_ch  = 8'(90 + k);
      cb_ch    = 8'(60 + k);
      cr_ch    = 8'(190 + k);
      step();
    end
    rst     = 1'b1;
    luma_ch = 8'd33;
    step();
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fails++; $display("FAIL midrst_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if ({red_ch, green_ch, blue_ch} !== 24'h0) begin
      n_fails++; $display("FAIL midrst_rgb: got %h want 000000", {red_ch, green_ch, blue_ch});
    end
    $display("midreset: out_valid=%b rgb=%h", out_valid, {red_ch, green_ch, blue_ch});
    @(negedge clk);
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fails++; $display("FAIL midrst_stale[%0d]: got %b want 0", cyc, out_valid);
      end
      step();
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    luma_ch   = 8'd0;
    cb_ch     = 8'd0;
    cr_ch     = 8'd0;
    @(negedge clk);
    test_reset();
    idle_cycles(2);
    test_grey();
    test_red();
    test_saturation();
    idle_cycles(2);
    test_backpressure();
    test_bubbles();
    idle_cycles(2);
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
